// File: rtl/bidicntr_sweep_ctrl.sv
// Sweep sequencer for the bidirectional counter: runs N triangle sweeps lo->hi->lo with an
// optional end-point dwell, and drives the counter direction (ctrl) and the count itself.
module bidicntr_sweep_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned SWEEP_W = 8,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [WIDTH-1:0]   i_lo,
    input  logic [WIDTH-1:0]   i_hi,
    input  logic [SWEEP_W-1:0] i_sweeps,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [WIDTH-1:0]   o_count,
    output logic               o_ctrl,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err,
    output logic [SWEEP_W-1:0] o_sweep_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StUp,
        StDwellHi,
        StDown,
        StDwellLo,
        StDone
    } state_e;

    state_e             r_state;
    logic [WIDTH-1:0]   r_count;
    logic               r_ctrl;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic [SWEEP_W-1:0] r_sweep_cnt;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [SWEEP_W-1:0] r_sweeps;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_timer;

    logic [WIDTH-1:0]   w_count_inc;
    logic [WIDTH-1:0]   w_count_dec;
    logic [SWEEP_W-1:0] w_sweep_inc;
    logic               w_cfg_bad;
    logic               w_active;
    logic               w_reach_hi;
    logic               w_reach_lo;
    logic               w_timer_last;
    logic               w_dwell_en;

    assign w_count_inc  = r_count + 1'b1;
    assign w_count_dec  = r_count - 1'b1;
    assign w_sweep_inc  = r_sweep_cnt + 1'b1;
    assign w_cfg_bad    = (i_lo >= i_hi) || (i_sweeps == '0);
    assign w_reach_hi   = (w_count_inc == r_hi);
    assign w_reach_lo   = (w_count_dec == r_lo);
    assign w_timer_last = (r_timer == DWELL_W'(1));
    assign w_dwell_en   = (r_dwell != '0);
    assign w_active     = (r_state == StUp) || (r_state == StDwellHi) ||
                          (r_state == StDown) || (r_state == StDwellLo);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_ctrl      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_sweep_cnt <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_sweeps    <= '0;
            r_dwell     <= '0;
            r_timer     <= '0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            // Abort freezes count and sweep_cnt where they are; only direction is re-armed.
            if (w_active && i_abort) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_ctrl  <= 1'b1;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (i_start && !i_abort) begin
                            if (w_cfg_bad) begin
                                r_cfg_err <= 1'b1;
                            end else begin
                                r_lo        <= i_lo;
                                r_hi        <= i_hi;
                                r_sweeps    <= i_sweeps;
                                r_dwell     <= i_dwell;
                                r_count     <= i_lo;
                                r_ctrl      <= 1'b1;
                                r_busy      <= 1'b1;
                                r_sweep_cnt <= '0;
                                r_state     <= StUp;
                            end
                        end
                    end
                    StUp: begin
                        r_count <= w_count_inc;
                        if (w_reach_hi) begin
                            if (w_dwell_en) begin
                                r_timer <= r_dwell;
                                r_state <= StDwellHi;
                            end else begin
                                r_ctrl  <= 1'b0;
                                r_state <= StDown;
                            end
                        end
                    end
                    StDwellHi: begin
                        if (w_timer_last) begin
                            r_ctrl  <= 1'b0;
                            r_state <= StDown;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    StDown: begin
                        r_count <= w_count_dec;
                        if (w_reach_lo) begin
                            r_sweep_cnt <= w_sweep_inc;
                            if (w_sweep_inc == r_sweeps) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= StDone;
                            end else if (w_dwell_en) begin
                                r_timer <= r_dwell;
                                r_state <= StDwellLo;
                            end else begin
                                r_ctrl  <= 1'b1;
                                r_state <= StUp;
                            end
                        end
                    end
                    StDwellLo: begin
                        if (w_timer_last) begin
                            r_ctrl  <= 1'b1;
                            r_state <= StUp;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_count     = r_count;
    assign o_ctrl      = r_ctrl;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;
    assign o_sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_bidicntr_sweep_ctrl.sv
// Randomized self-checking bench for bidicntr_sweep_ctrl; expected per-cycle outputs come from a
// trace built directly from the sweep rules (ramp up, dwell, ramp down, dwell, repeat).
module tb_bidicntr_sweep_ctrl;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [3:0] i_lo = '0;
    logic [3:0] i_hi = '0;
    logic [7:0] i_sweeps = '0;
    logic [3:0] i_dwell = '0;
    logic [3:0] o_count;
    logic       o_ctrl;
    logic       o_busy;
    logic       o_done;
    logic       o_cfg_err;
    logic [7:0] o_sweep_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] count;
        logic       ctrl;
        logic       busy;
        logic       done;
        logic [7:0] sc;
        bit         chk_ctrl;
    } exp_t;

    exp_t q[$];

    bidicntr_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8), .DWELL_W(4)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_lo        (i_lo),
        .i_hi        (i_hi),
        .i_sweeps    (i_sweeps),
        .i_dwell     (i_dwell),
        .o_count     (o_count),
        .o_ctrl      (o_ctrl),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err),
        .o_sweep_cnt (o_sweep_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input int c, input bit ct, input bit b, input bit d,
                                 input int sc, input bit chk);
        exp_t e;
        e.count = 4'(c);
        e.ctrl = ct;
        e.busy = b;
        e.done = d;
        e.sc = 8'(sc);
        e.chk_ctrl = chk;
        q.push_back(e);
    endfunction

    // Expected outputs from the accept edge onward, ending with the first idle cycle after done.
    function automatic void build_trace(input int lo, input int hi, input int n, input int d);
        q.delete();
        for (int s = 0; s < n; s++) begin
            if (s == 0) push(lo, 1, 1, 0, 0, 1);
            for (int v = lo + 1; v < hi; v++) push(v, 1, 1, 0, s, 1);
            for (int k = 0; k < d; k++) push(hi, 1, 1, 0, s, 1);
            push(hi, 0, 1, 0, s, 1);
            for (int v = hi - 1; v > lo; v--) push(v, 0, 1, 0, s, 1);
            if (s == n - 1) begin
                push(lo, 0, 0, 1, n, 1);
                push(lo, 0, 0, 0, n, 0);
            end else begin
                for (int k = 0; k < d; k++) push(lo, 0, 1, 0, s + 1, 1);
                push(lo, 1, 1, 0, s + 1, 1);
            end
        end
    endfunction

    task automatic accept(input int lo, input int hi, input int n, input int d, input bit hold);
        i_lo = 4'(lo);
        i_hi = 4'(hi);
        i_sweeps = 8'(n);
        i_dwell = 4'(d);
        i_start = 1'b1;
        step();
        if (!hold) i_start = 1'b0;
    endtask

    task automatic play_trace(input string name, input int abort_at,
                              output int busy_cyc, output int done_cyc);
        busy_cyc = 0;
        done_cyc = 0;
        for (int i = 0; i < q.size(); i++) begin
            n_checks++;
            if (o_count !== q[i].count || o_busy !== q[i].busy || o_done !== q[i].done ||
                o_sweep_cnt !== q[i].sc || o_cfg_err !== 1'b0 ||
                (q[i].chk_ctrl && o_ctrl !== q[i].ctrl)) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got count=%0d ctrl=%b busy=%b done=%b sc=%0d cfg_err=%b, want count=%0d ctrl=%b busy=%b done=%b sc=%0d cfg_err=0",
                         name, i, o_count, o_ctrl, o_busy, o_done, o_sweep_cnt, o_cfg_err,
                         q[i].count, q[i].ctrl, q[i].busy, q[i].done, q[i].sc);
            end
            busy_cyc += int'(o_busy);
            done_cyc += int'(o_done);
            if (i == abort_at) begin
                i_abort = 1'b1;
                step();
                i_abort = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (o_count !== q[i].count || o_busy !== 1'b0 || o_ctrl !== 1'b1 ||
                        o_done !== 1'b0 || o_sweep_cnt !== q[i].sc) begin
                        n_errors++;
                        $display("FAIL %s abort+%0d: got count=%0d busy=%b ctrl=%b done=%b sc=%0d, want count=%0d busy=0 ctrl=1 done=0 sc=%0d",
                                 name, k, o_count, o_busy, o_ctrl, o_done, o_sweep_cnt,
                                 q[i].count, q[i].sc);
                    end
                    step();
                end
                return;
            end
            if (i < q.size() - 1) step();
        end
    endtask

    task automatic check_len(input string name, input int busy_cyc, input int done_cyc,
                             input int lo, input int hi, input int n, input int d);
        int want;
        want = 2 * n * (hi - lo) + 2 * n * d - d;
        n_checks++;
        if (busy_cyc != want || done_cyc != 1) begin
            n_errors++;
            $display("FAIL %s length: busy=%0d done_pulses=%0d, want busy=%0d done_pulses=1",
                     name, busy_cyc, done_cyc, want);
        end
    endtask

    task automatic test_reset();
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if (o_count !== 4'd0 || o_ctrl !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_cfg_err !== 1'b0 || o_sweep_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset: got count=%0d ctrl=%b busy=%b done=%b cfg_err=%b sc=%0d, want 0 1 0 0 0 0",
                     o_count, o_ctrl, o_busy, o_done, o_cfg_err, o_sweep_cnt);
        end
        i_reset = 1'b1;
        step();
    endtask

    task automatic test_single_sweep();
        int b, d;
        build_trace(2, 5, 1, 0);
        accept(2, 5, 1, 0, 1'b0);
        play_trace("single_sweep", -1, b, d);
        check_len("single_sweep", b, d, 2, 5, 1, 0);
    endtask

    task automatic test_dwell_sweeps();
        int b, d;
        build_trace(0, 15, 2, 3);
        accept(0, 15, 2, 3, 1'b0);
        play_trace("dwell_sweeps", -1, b, d);
        check_len("dwell_sweeps", b, d, 0, 15, 2, 3);
    endtask

    task automatic test_cfg_err();
        logic [3:0] held;
        int cfg_lo[3] = '{7, 1, 9};
        int cfg_hi[3] = '{7, 9, 4};
        int cfg_n[3]  = '{3, 0, 1};
        held = o_count;
        for (int t = 0; t < 3; t++) begin
            accept(cfg_lo[t], cfg_hi[t], cfg_n[t], 1, 1'b0);
            n_checks++;
            if (o_cfg_err !== 1'b1 || o_busy !== 1'b0 || o_count !== held) begin
                n_errors++;
                $display("FAIL cfg_err[%0d] pulse: got cfg_err=%b busy=%b count=%0d, want 1 0 %0d",
                         t, o_cfg_err, o_busy, o_count, held);
            end
            step();
            n_checks++;
            if (o_cfg_err !== 1'b0 || o_busy !== 1'b0 || o_count !== held) begin
                n_errors++;
                $display("FAIL cfg_err[%0d] after: got cfg_err=%b busy=%b count=%0d, want 0 0 %0d",
                         t, o_cfg_err, o_busy, o_count, held);
            end
        end
    endtask

    task automatic test_abort();
        int b, d;
        build_trace(3, 12, 2, 1);
        accept(3, 12, 2, 1, 1'b0);
        play_trace("abort_up", 6, b, d);
        // Abort together with start in IDLE must leave everything untouched.
        i_abort = 1'b1;
        accept(2, 5, 1, 0, 1'b0);
        i_abort = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_cfg_err !== 1'b0 || o_count !== 4'd9) begin
            n_errors++;
            $display("FAIL abort_wins_start: got busy=%b cfg_err=%b count=%0d, want 0 0 9",
                     o_busy, o_cfg_err, o_count);
        end
        step();
    endtask

    task automatic test_start_held();
        int b, d;
        build_trace(4, 6, 2, 1);
        accept(4, 6, 2, 1, 1'b1);
        // New config presented while busy; must only take effect on the re-accept after DONE.
        i_lo = 4'd1;
        i_hi = 4'd3;
        i_sweeps = 8'd1;
        i_dwell = 4'd0;
        play_trace("start_held", -1, b, d);
        check_len("start_held", b, d, 4, 6, 2, 1);
        step();
        i_start = 1'b0;
        build_trace(1, 3, 1, 0);
        play_trace("start_held_reaccept", -1, b, d);
        check_len("start_held_reaccept", b, d, 1, 3, 1, 0);
    endtask

    task automatic test_random();
        int lo, hi, n, d, ab, b, dn;
        for (int it = 0; it < 8; it++) begin
            lo = int'($urandom_range(0, 13));
            hi = int'($urandom_range(lo + 1, 15));
            n = int'($urandom_range(1, 3));
            d = int'($urandom_range(0, 3));
            build_trace(lo, hi, n, d);
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, q.size() - 3)) : -1;
            accept(lo, hi, n, d, 1'b0);
            play_trace($sformatf("random%0d", it), ab, b, dn);
            if (ab < 0) check_len($sformatf("random%0d", it), b, dn, lo, hi, n, d);
            step();
        end
    endtask

    task automatic test_reset_mid();
        build_trace(1, 8, 1, 0);
        accept(1, 8, 1, 0, 1'b0);
        repeat (10) step();
        n_checks++;
        if (o_count !== q[10].count || o_ctrl !== q[10].ctrl || o_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid pre: got count=%0d ctrl=%b busy=%b, want %0d %b 1",
                     o_count, o_ctrl, o_busy, q[10].count, q[10].ctrl);
        end
        #2 i_reset = 1'b0;
        #1;
        n_checks++;
        if (o_count !== 4'd0 || o_busy !== 1'b0 || o_ctrl !== 1'b1 || o_done !== 1'b0 ||
            o_sweep_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_mid async: got count=%0d busy=%b ctrl=%b done=%b sc=%0d, want 0 0 1 0 0",
                     o_count, o_busy, o_ctrl, o_done, o_sweep_cnt);
        end
        step();
        #2 i_reset = 1'b1;
        repeat (2) step();
        n_checks++;
        if (o_count !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ctrl !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid release: got count=%0d busy=%b done=%b ctrl=%b, want 0 0 0 1",
                     o_count, o_busy, o_done, o_ctrl);
        end
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_dwell_sweeps();
        test_cfg_err();
        test_abort();
        test_start_held();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
